user_csr_trap_unit: RTL
=======================

# user_csr_trap_unit

User-mode CSR file and trap sequencer for the RISC-V core. It consumes the exception-record outputs of the exception controller: register-write strobe, PC-redirect request, UEPC, UCAUSE and UTVAL. It holds the N-extension CSRs, serves CSR instructions, and arbitrates the external interrupt. It returns the handler vector on trap entry and the resume PC on URET, tracking handler occupancy with a small state machine.

## Interface
Parameters:
- `UTVEC_RESET`, default 32'h0000_0000: reset value of utvec.
- `IRQ_CAUSE`, default 32'h8000_0008: ucause value written on user external interrupt.

Ports:
- `iCLK` in 1: core clock.
- `iRST` in 1: reset. One clock; reset is synchronous and active-high.
- `iExRegWrite` in 1: exception record valid this cycle.
- `iExSetPcToUtvec` in 1: exception requests redirect to utvec. It is 0 for ecall; the PC mux handles ecall.
- `iExUEPC` in 32: faulting PC.
- `iExUCAUSE` in 32: cause code.
- `iExUTVAL` in 32: trap value.
- `iCsrEn` in 1: CSR instruction executing this cycle.
- `iCsrOp` in 2: funct3[1:0]. 01 = RW, 10 = RS, 11 = RC, 00 = no-op.
- `iCsrAddr` in 12: CSR address.
- `iCsrWData` in 32: rs1 value or zero-extended uimm.
- `iUret` in 1: URET executing.
- `iExtIrq` in 1: level-sensitive external interrupt request.
- `iInstrBoundary` in 1: high when the next instruction may be replaced (interrupt point).
- `iPC` in 32: PC of the instruction about to issue, sampled at the boundary.
- `oCsrRData` out 32: old CSR value (combinational).
- `oCsrIllegal` out 1: iCsrEn with an unmapped address (combinational).
- `oTrapTaken` out 1: redirect to oTrapVector this cycle (combinational).
- `oTrapVector` out 32: {utvec[31:2], 2'b00}.
- `oUretPC` out 32: uepc.
- `oInHandler` out 1: state is TRAP.
- `oDoubleFault` out 1: state is HALT.

## Operation
- CSR map: ustatus 0x000 (bit0 UIE, bit4 UPIE; other bits read 0), uie 0x004 (bit8 UEIE only), utvec 0x005 (bits[1:0] forced 0), uscratch 0x040, uepc 0x041, ucause 0x042, utval 0x043, uip 0x044 (bit8 UEIP = registered iExtIrq, read-only).
- CSR writes:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with wdata = 0 writes nothing.
  - Writes to uip are ignored.
  - An unmapped address writes nothing and raises oCsrIllegal.
- Interrupt request: irq = ustatus.UIE & uie.UEIE & uip.UEIP & iInstrBoundary & state == RUN & ~iExRegWrite.
- States: RUN, TRAP, HALT.
- RUN, on iExRegWrite:
  - Latch uepc ← iExUEPC, ucause ← iExUCAUSE, utval ← iExUTVAL.
  - UPIE ← UIE, UIE ← 0. Go to TRAP.
  - oTrapTaken = iExSetPcToUtvec.
- RUN, on irq:
  - Latch uepc ← iPC, ucause ← IRQ_CAUSE, utval ← 0.
  - UPIE ← UIE, UIE ← 0. Go to TRAP.
  - oTrapTaken = 1.
- TRAP, on iUret: UIE ← UPIE, UPIE ← 1. Go to RUN. The PC unit uses oUretPC.
- TRAP, on iExRegWrite: nested fault.
  - Go to HALT. uepc, ucause and utval are not overwritten.
  - oTrapTaken = 0 thereafter.
- HALT: exits only on iRST.
- URET in RUN is a no-op; state stays RUN.
- Priority in one cycle: exception > interrupt > CSR write to the same CSR. A trap entry overrides a simultaneous CSR write to ustatus, uepc, ucause or utval.
- A CSR write to an unrelated CSR in the same cycle still commits.

## Timing
- Reset: every CSR = 0 except utvec = UTVEC_RESET; state RUN.
- Outputs after reset: oTrapTaken = 0, oInHandler = 0, oDoubleFault = 0, oCsrIllegal = 0, oCsrRData = 0 (for any address), oUretPC = 0, oTrapVector = UTVEC_RESET & ~3.
- Reset wins over every input in the same cycle, including mid-handler.
- CSR read: combinational, returns the pre-update value. Written data is visible the next cycle (read-modify-write in one cycle).
- Trap entry:
  - oTrapTaken is combinational in the cycle of iExRegWrite or irq.
  - CSR updates and the state change land on the next rising edge.
  - oInHandler rises 1 cycle after entry.
- URET: oUretPC is valid in the same cycle. oInHandler falls next edge.
- uip.UEIP lags iExtIrq by 1 cycle, so interrupt latency from iExtIrq rising is ≥2 cycles.

## Test plan
- Reset then read every CSR: utvec = UTVEC_RESET, all others 0, oInHandler = 0.
- CSRRW utvec = 0x0040_0103, then CSRRS ustatus with 0x1. Next cycle: utvec reads 0x0040_0100, ustatus reads 0x1. RS with wdata 0 leaves values unchanged.
- iExRegWrite, SetPc = 1, UEPC 0x0040_0006, CAUSE 0, UTVAL 0x0040_0006, with UIE = 1. Same cycle: oTrapTaken = 1, vector 0x0040_0100. Next cycle: uepc/utval = 0x0040_0006, ustatus = 0x10, oInHandler = 1.
- Then iUret: oUretPC = 0x0040_0006. Next cycle: ustatus = 0x11, oInHandler = 0.
- UIE = 1, UEIE = 1, iExtIrq = 1, boundary with iPC = 0x0040_0020. Required: oTrapTaken = 1, ucause = 0x8000_0008, uepc = 0x0040_0020. Repeat with a simultaneous iExRegWrite (cause 2): the exception is recorded and the interrupt stays pending.
- In TRAP, assert iExRegWrite (cause 5). Required: oDoubleFault = 1, ucause unchanged, iUret ignored. iRST returns to RUN with all CSRs reset.

Source files
------------

// File: rtl/user_csr_trap_unit.sv
// User-mode (N-extension) CSR file and trap sequencer: serves CSR instructions,
// records exceptions/external interrupts, and tracks handler occupancy (RUN/TRAP/HALT).
module user_csr_trap_unit #(
    parameter logic [31:0] UTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] IRQ_CAUSE   = 32'h8000_0008
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iExRegWrite,
    input  logic        iExSetPcToUtvec,
    input  logic [31:0] iExUEPC,
    input  logic [31:0] iExUCAUSE,
    input  logic [31:0] iExUTVAL,
    input  logic        iCsrEn,
    input  logic [1:0]  iCsrOp,
    input  logic [11:0] iCsrAddr,
    input  logic [31:0] iCsrWData,
    input  logic        iUret,
    input  logic        iExtIrq,
    input  logic        iInstrBoundary,
    input  logic [31:0] iPC,
    output logic [31:0] oCsrRData,
    output logic        oCsrIllegal,
    output logic        oTrapTaken,
    output logic [31:0] oTrapVector,
    output logic [31:0] oUretPC,
    output logic        oInHandler,
    output logic        oDoubleFault
);

    typedef enum logic [1:0] {RUN, TRAP, HALT} state_t;

    localparam logic [11:0] A_USTATUS  = 12'h000;
    localparam logic [11:0] A_UIE      = 12'h004;
    localparam logic [11:0] A_UTVEC    = 12'h005;
    localparam logic [11:0] A_USCRATCH = 12'h040;
    localparam logic [11:0] A_UEPC     = 12'h041;
    localparam logic [11:0] A_UCAUSE   = 12'h042;
    localparam logic [11:0] A_UTVAL    = 12'h043;
    localparam logic [11:0] A_UIP      = 12'h044;

    state_t      state_q, state_d;
    logic        uie_q, uie_d;
    logic        upie_q, upie_d;
    logic        ueie_q, ueie_d;
    logic        ueip_q;
    logic [31:0] utvec_q, utvec_d;
    logic [31:0] uscratch_q, uscratch_d;
    logic [31:0] uepc_q, uepc_d;
    logic [31:0] ucause_q, ucause_d;
    logic [31:0] utval_q, utval_d;

    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic        csr_hit;
    logic        csr_we;
    logic        irq;
    logic        trap_entry;
    logic        uret_fire;

    always_comb begin
        csr_old = '0;
        csr_hit = 1'b1;
        case (iCsrAddr)
            A_USTATUS:  csr_old = {27'b0, upie_q, 3'b0, uie_q};
            A_UIE:      csr_old = {23'b0, ueie_q, 8'b0};
            A_UTVEC:    csr_old = utvec_q;
            A_USCRATCH: csr_old = uscratch_q;
            A_UEPC:     csr_old = uepc_q;
            A_UCAUSE:   csr_old = ucause_q;
            A_UTVAL:    csr_old = utval_q;
            A_UIP:      csr_old = {23'b0, ueip_q, 8'b0};
            default:    csr_hit = 1'b0;
        endcase
    end

    always_comb begin
        case (iCsrOp)
            2'b01:   csr_new = iCsrWData;
            2'b10:   csr_new = csr_old | iCsrWData;
            2'b11:   csr_new = csr_old & ~iCsrWData;
            default: csr_new = csr_old;
        endcase
    end

    // RS/RC with a zero mask are pure reads; uip is read-only.
    assign csr_we = iCsrEn && csr_hit && (iCsrAddr != A_UIP) &&
                    ((iCsrOp == 2'b01) || (iCsrOp[1] && (iCsrWData != 32'b0)));

    assign oCsrRData   = csr_old;
    assign oCsrIllegal = iCsrEn && !csr_hit;

    assign irq = uie_q && ueie_q && ueip_q && iInstrBoundary &&
                 (state_q == RUN) && !iExRegWrite;
    assign trap_entry = (state_q == RUN) && (iExRegWrite || irq);
    assign uret_fire  = (state_q == TRAP) && iUret && !iExRegWrite;

    always_comb begin
        state_d    = state_q;
        oTrapTaken = 1'b0;
        case (state_q)
            RUN: begin
                if (iExRegWrite) begin
                    state_d    = TRAP;
                    oTrapTaken = iExSetPcToUtvec;
                end else if (irq) begin
                    state_d    = TRAP;
                    oTrapTaken = 1'b1;
                end
            end
            TRAP: begin
                if (iExRegWrite) begin
                    state_d = HALT;
                end else if (iUret) begin
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        uie_d      = uie_q;
        upie_d     = upie_q;
        ueie_d     = ueie_q;
        utvec_d    = utvec_q;
        uscratch_d = uscratch_q;
        uepc_d     = uepc_q;
        ucause_d   = ucause_q;
        utval_d    = utval_q;

        if (csr_we) begin
            case (iCsrAddr)
                A_USTATUS: begin
                    uie_d  = csr_new[0];
                    upie_d = csr_new[4];
                end
                A_UIE:      ueie_d     = csr_new[8];
                A_UTVEC:    utvec_d    = {csr_new[31:2], 2'b00};
                A_USCRATCH: uscratch_d = csr_new;
                A_UEPC:     uepc_d     = csr_new;
                A_UCAUSE:   ucause_d   = csr_new;
                A_UTVAL:    utval_d    = csr_new;
                default: ;
            endcase
        end

        // Trap bookkeeping takes precedence over a same-cycle CSR write.
        if (trap_entry) begin
            upie_d = uie_q;
            uie_d  = 1'b0;
            if (iExRegWrite) begin
                uepc_d   = iExUEPC;
                ucause_d = iExUCAUSE;
                utval_d  = iExUTVAL;
            end else begin
                uepc_d   = iPC;
                ucause_d = IRQ_CAUSE;
                utval_d  = 32'b0;
            end
        end else if (uret_fire) begin
            uie_d  = upie_q;
            upie_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= RUN;
            uie_q      <= 1'b0;
            upie_q     <= 1'b0;
            ueie_q     <= 1'b0;
            ueip_q     <= 1'b0;
            utvec_q    <= UTVEC_RESET;
            uscratch_q <= '0;
            uepc_q     <= '0;
            ucause_q   <= '0;
            utval_q    <= '0;
        end else begin
            state_q    <= state_d;
            uie_q      <= uie_d;
            upie_q     <= upie_d;
            ueie_q     <= ueie_d;
            ueip_q     <= iExtIrq;
            utvec_q    <= utvec_d;
            uscratch_q <= uscratch_d;
            uepc_q     <= uepc_d;
            ucause_q   <= ucause_d;
            utval_q    <= utval_d;
        end
    end

    assign oTrapVector  = {utvec_q[31:2], 2'b00};
    assign oUretPC      = uepc_q;
    assign oInHandler   = (state_q == TRAP);
    assign oDoubleFault = (state_q == HALT);

endmodule
